// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 32-bit Fibonacci LFSR among NUM_REQ requesters.
// Define RNG_SYMMETRIC_EN to deliver nibble 4'b1000 as 0 (range -7..+7).
`timescale 1ns/1ps
module rng_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          STIR_CYCLES = 4,
  parameter logic [31:0] SEED        = 32'hAEAF696C
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [31:0]        seed_value,
  output logic               busy,
  output logic [2:0]         gnt_id,
  output logic               rnd_valid,
  output logic [31:0]        rnd_data
);

  localparam int                CNT_W    = $clog2(STIR_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STIR_CYCLES - 1);
  localparam logic [2:0]        LAST_ID  = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, STIR, DELIVER} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       rr_ptr_reg, rr_ptr_next;
  logic [2:0]       gnt_reg, gnt_next;
  logic             valid_reg, valid_next;
  logic [31:0]      data_reg, data_next;

  logic [7:0]         req_pad;
  logic [NUM_REQ-1:0] rot_req;
  logic [2:0]         rot_idx [NUM_REQ];
  logic               pick_valid;
  logic [2:0]         pick_id;
  logic [31:0]        lfsr_shift;
  logic [3:0]         nib_out;

  assign req_pad    = 8'(req);
  assign lfsr_shift = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[6] ^ lfsr_reg[5] ^ lfsr_reg[1]};

  // Requests rotated so that offset 0 is the current round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [3:0] pos;
      assign pos          = {1'b0, rr_ptr_reg} + 4'(gi);
      assign rot_idx[gi]  = (pos >= 4'(NUM_REQ)) ? 3'(pos - 4'(NUM_REQ)) : pos[2:0];
      assign rot_req[gi]  = req_pad[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_valid = 1'b1;
        pick_id    = rot_idx[i];
      end
    end
  end

  always_comb begin
    nib_out = lfsr_shift[3:0];
`ifdef RNG_SYMMETRIC_EN
    if (lfsr_shift[3:0] == 4'b1000) nib_out = 4'b0000;
`endif
  end

  always_comb begin
    state_next  = state_reg;
    lfsr_next   = lfsr_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_next    = gnt_reg;
    valid_next  = 1'b0;
    data_next   = data_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick_id;
          cnt_next   = CNT_LAST;
          state_next = STIR;
        end
      end
      STIR: begin
        lfsr_next = lfsr_shift;
        // An aborted grant keeps its shifts but leaves the pointer alone.
        if (!req_pad[gnt_reg]) begin
          state_next = IDLE;
        end else if (seed_load) begin
          cnt_next = CNT_LAST;
        end else if (cnt_reg == '0) begin
          state_next = DELIVER;
          valid_next = 1'b1;
          data_next  = {{28{nib_out[3]}}, nib_out};
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DELIVER: begin
        rr_ptr_next = (gnt_reg == LAST_ID) ? 3'd0 : gnt_reg + 3'd1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A zero seed would lock the LFSR, so it falls back to SEED.
    if (seed_load) lfsr_next = (seed_value == 32'd0) ? SEED : seed_value;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      lfsr_reg   <= SEED;
      cnt_reg    <= '0;
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_reg    <= gnt_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign gnt_id    = gnt_reg;
  assign rnd_valid = valid_reg;
  assign rnd_data  = data_reg;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter against a transaction-level model
// (LFSR stepped per grant, round-robin pick computed arithmetically).
`timescale 1ns/1ps
module tb_rng_arbiter;
  localparam int          NUM_REQ = 4;
  localparam int          STIR    = 4;
  localparam int          LAT     = STIR + 1;
  localparam logic [31:0] SEED    = 32'hAEAF696C;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_value = '0;
  logic        busy;
  logic [2:0]  gnt_id;
  logic        rnd_valid;
  logic [31:0] rnd_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] m_lfsr;
  int          m_rr;

  rng_arbiter #(.NUM_REQ(NUM_REQ), .STIR_CYCLES(STIR), .SEED(SEED)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .seed_load(seed_load),
    .seed_value(seed_value), .busy(busy), .gnt_id(gnt_id),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x, input int n);
    logic [31:0] s;
    s = x;
    for (int i = 0; i < n; i++) s = {s[30:0], s[31] ^ s[6] ^ s[5] ^ s[1]};
    return s;
  endfunction

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (r[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [31:0] value_of(input logic [31:0] l);
    int v;
    v = int'(l[3:0]);
    if (v >= 8) v = v - 16;
`ifdef RNG_SYMMETRIC_EN
    if (v == -8) v = 0;
`endif
    return v;
  endfunction

  task automatic do_reset();
    req = '0; seed_load = 1'b0; seed_value = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_lfsr = SEED;
    m_rr   = 0;
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (rnd_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (rnd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
    tests_run++; if (rnd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", rnd_data); end
    tests_run++; if (gnt_id !== 3'd0) begin tests_failed++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
    reset_n = 1'b1;
    req = 4'b0100;
    repeat (2) @(negedge clock);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL pre_async_busy: got %b expected 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    tests_run++; if (gnt_id !== 3'd0) begin tests_failed++; $display("FAIL async_reset_gnt: got %0d expected 0", gnt_id); end
    req = '0;
    $display("[TB] reset checks done");
  endtask

  task automatic test_single();
    int cyc; bit seen; int exp_id; logic [31:0] exp_l;
    logic [31:0] const_data [2];
    const_data[0] = 32'hFFFFFFFF;
    const_data[1] = 32'hFFFFFFFA;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req = 4'b0001;
      exp_id = pick(req, m_rr);
      exp_l = lfsr_step(m_lfsr, STIR);
      wait_valid(20, cyc, seen);
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL single_seen%0d: got %b expected 1", k, seen); end
      tests_run++; if (cyc != LAT) begin tests_failed++; $display("FAIL single_latency%0d: got %0d expected %0d", k, cyc, LAT); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy%0d: got %b expected 1", k, busy); end
      tests_run++; if (gnt_id !== 3'(exp_id)) begin tests_failed++; $display("FAIL single_gnt%0d: got %0d expected %0d", k, gnt_id, exp_id); end
      tests_run++; if (rnd_data !== value_of(exp_l)) begin tests_failed++; $display("FAIL single_model%0d: got %h expected %h", k, rnd_data, value_of(exp_l)); end
      tests_run++; if (rnd_data !== const_data[k]) begin tests_failed++; $display("FAIL single_const%0d: got %h expected %h", k, rnd_data, const_data[k]); end
      $display("[TB] single id=%0d data=%h latency=%0d", gnt_id, rnd_data, cyc);
      m_lfsr = exp_l;
      m_rr = (exp_id + 1) % NUM_REQ;
      req = '0;
      @(negedge clock);
      tests_run++; if (rnd_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pulse%0d: got %b expected 0", k, rnd_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; int exp_id; logic [31:0] exp_l;
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      exp_id = pick(req, m_rr);
      exp_l = lfsr_step(m_lfsr, STIR);
      wait_valid(20, cyc, seen);
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL b2b_seen%0d: got %b expected 1", k, seen); end
      tests_run++; if (cyc != ((k == 0) ? LAT : LAT + 1)) begin tests_failed++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, cyc, (k == 0) ? LAT : LAT + 1); end
      tests_run++; if (gnt_id !== 3'(exp_id)) begin tests_failed++; $display("FAIL b2b_gnt%0d: got %0d expected %0d", k, gnt_id, exp_id); end
      tests_run++; if (gnt_id !== 3'(order[k])) begin tests_failed++; $display("FAIL b2b_order%0d: got %0d expected %0d", k, gnt_id, order[k]); end
      tests_run++; if (rnd_data !== value_of(exp_l)) begin tests_failed++; $display("FAIL b2b_data%0d: got %h expected %h", k, rnd_data, value_of(exp_l)); end
      $display("[TB] b2b id=%0d data=%h spacing=%0d", gnt_id, rnd_data, cyc);
      m_lfsr = exp_l;
      m_rr = (exp_id + 1) % NUM_REQ;
    end
    req = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_seed_zero();
    int cyc; bit seen; logic [31:0] exp_l;
    do_reset();
    req = 4'b0001;
    repeat (2) @(negedge clock);
    seed_load = 1'b1;
    seed_value = 32'd0;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr = SEED;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL seed0_busy: got %b expected 1", busy); end
    exp_l = lfsr_step(m_lfsr, STIR);
    wait_valid(20, cyc, seen);
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL seed0_seen: got %b expected 1", seen); end
    tests_run++; if (cyc != STIR) begin tests_failed++; $display("FAIL seed0_latency: got %0d expected %0d", cyc, STIR); end
    tests_run++; if (rnd_data !== value_of(exp_l)) begin tests_failed++; $display("FAIL seed0_data: got %h expected %h", rnd_data, value_of(exp_l)); end
    tests_run++; if (rnd_data !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL seed0_const: got %h expected ffffffff", rnd_data); end
    $display("[TB] seed0 id=%0d data=%h latency=%0d", gnt_id, rnd_data, cyc);
    m_lfsr = exp_l;
    m_rr = 1;
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_abort();
    int cyc; bit seen; bit any_valid; int exp_id; logic [31:0] exp_l; logic [31:0] last_data;
    do_reset();
    req = 4'b0010;
    exp_l = lfsr_step(m_lfsr, STIR);
    wait_valid(20, cyc, seen);
    tests_run++; if (gnt_id !== 3'd1 || seen !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_gnt: got %0d seen %b expected 1 seen 1", gnt_id, seen); end
    m_lfsr = exp_l;
    m_rr = 2;
    last_data = value_of(exp_l);
    req = '0;
    @(negedge clock);
    req = 4'b0100;
    repeat (2) @(negedge clock);
    req = '0;
    m_lfsr = lfsr_step(m_lfsr, 2);
    any_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (rnd_valid) any_valid = 1'b1;
    repeat (7) begin
      @(negedge clock);
      if (rnd_valid) any_valid = 1'b1;
    end
    tests_run++; if (any_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid: got %b expected 0", any_valid); end
    tests_run++; if (rnd_data !== last_data) begin tests_failed++; $display("FAIL abort_hold: got %h expected %h", rnd_data, last_data); end
    $display("[TB] abort id=2 dropped, data held=%h", rnd_data);
    req = 4'b0111;
    exp_id = pick(req, m_rr);
    exp_l = lfsr_step(m_lfsr, STIR);
    wait_valid(20, cyc, seen);
    tests_run++; if (gnt_id !== 3'(exp_id) || seen !== 1'b1) begin tests_failed++; $display("FAIL abort_regrant: got %0d seen %b expected %0d seen 1", gnt_id, seen, exp_id); end
    tests_run++; if (rnd_data !== value_of(exp_l)) begin tests_failed++; $display("FAIL abort_data: got %h expected %h", rnd_data, value_of(exp_l)); end
    $display("[TB] abort regrant id=%0d data=%h", gnt_id, rnd_data);
    m_lfsr = exp_l;
    m_rr = (exp_id + 1) % NUM_REQ;
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_symmetric();
    int cyc; bit seen; bit found; logic [31:0] s; logic [31:0] l; logic [31:0] exp_c;
    found = 1'b0;
    s = 32'd1;
    for (int t = 0; t < 2000 && !found; t++) begin
      s = $urandom;
      l = lfsr_step(s, STIR);
      if (s != 32'd0 && l[3:0] == 4'b1000) found = 1'b1;
    end
`ifdef RNG_SYMMETRIC_EN
    exp_c = 32'd0;
`else
    exp_c = 32'hFFFFFFF8;
`endif
    do_reset();
    seed_load = 1'b1;
    seed_value = s;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr = s;
    req = 4'b0001;
    wait_valid(20, cyc, seen);
    tests_run++; if (seen !== 1'b1 || !found) begin tests_failed++; $display("FAIL sym_seen: got %b (seed found %b) expected 1", seen, found); end
    tests_run++; if (rnd_data !== exp_c) begin tests_failed++; $display("FAIL sym_data: got %h expected %h", rnd_data, exp_c); end
    $display("[TB] sym seed=%h data=%h", s, rnd_data);
    m_lfsr = lfsr_step(s, STIR);
    m_rr = 1;
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_random();
    int cyc; bit seen; int exp_id; logic [31:0] exp_l; logic [3:0] r; bit ld; logic [31:0] sv;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r  = 4'($urandom_range(1, 15));
      ld = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      req = r;
      seed_load = ld;
      seed_value = sv;
      if (ld) m_lfsr = (sv == 32'd0) ? SEED : sv;
      exp_id = pick(r, m_rr);
      exp_l = lfsr_step(m_lfsr, STIR);
      @(negedge clock);
      seed_load = 1'b0;
      wait_valid(20, cyc, seen);
      cyc = cyc + 1;
      tests_run++; if (seen !== 1'b1 || cyc != LAT) begin tests_failed++; $display("FAIL rand_latency%0d: got %0d seen %b expected %0d", n, cyc, seen, LAT); end
      tests_run++; if (gnt_id !== 3'(exp_id)) begin tests_failed++; $display("FAIL rand_gnt%0d: got %0d expected %0d req %b", n, gnt_id, exp_id, r); end
      tests_run++; if (rnd_data !== value_of(exp_l)) begin tests_failed++; $display("FAIL rand_data%0d: got %h expected %h", n, rnd_data, value_of(exp_l)); end
      $display("[TB] rand req=%b load=%0d id=%0d data=%h", r, ld, gnt_id, rnd_data);
      m_lfsr = exp_l;
      m_rr = (exp_id + 1) % NUM_REQ;
      req = '0;
      @(negedge clock);
      tests_run++; if (rnd_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_pulse%0d: got %b expected 0", n, rnd_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_seed_zero();
    test_abort();
    test_symmetric();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
